ps2_host_tx: RTL and testbench



---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_line_filter.sv | 50 +++++
 rtl/ps2_host_tx.sv | 181 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmit path.
// Also used by the keyboard receive path for command/response codes.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SEND,
    ACK,
    WAIT_IDLE
  } state_t;

  localparam logic [7:0] PS2_CMD_LEDS = 8'hED;
  localparam logic [7:0] PS2_ACK      = 8'hFA;
  localparam logic [7:0] PS2_RESEND   = 8'hFE;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// 2-FF synchronizer plus stability filter for one PS/2 line.
// Level moves only after FILTER_LEN equal consecutive synced samples.
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic raw,
  output logic sync,
  output logic level,
  output logic fall,
  output logic rise
);

  localparam int unsigned CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CMAX = CW'(FILTER_LEN - 1);

  logic meta;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      meta  <= 1'b1;
      sync  <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      fall  <= 1'b0;
      rise  <= 1'b0;
    end else begin
      meta <= raw;
      sync <= meta;
      fall <= 1'b0;
      rise <= 1'b0;
      if (sync == level) begin
        cnt <= '0;
      end else if (cnt == CMAX) begin
        // sync has now differed for FILTER_LEN samples in a row
        cnt   <= '0;
        level <= sync;
        fall  <= ~sync;
        rise  <= sync;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter driving open-drain clock/data.
// Reports device acknowledge as tx_done, missing ack or timeout as tx_error.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 9600,
  parameter int unsigned TIMEOUT_CYCLES = 1440000,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int unsigned IW = $clog2(INHIBIT_CYCLES);
  localparam logic [IW-1:0] ILAST = IW'(INHIBIT_CYCLES - 2);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

  state_t        state, state_n;
  logic [8:0]    shift, shift_n;
  logic [3:0]    idx, idx_n;
  logic [IW-1:0] icnt, icnt_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic          clk_oe_n, dat_oe_n;
  logic          done_c, err_c;
  logic          abort, timeout;

  logic clk_sync, clk_level, clk_fall, clk_rise;
  logic dat_sync, dat_level, dat_fall, dat_rise;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk_sys (clk_sys),
    .reset   (reset),
    .raw     (ps2_clk_in),
    .sync    (clk_sync),
    .level   (clk_level),
    .fall    (clk_fall),
    .rise    (clk_rise)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
    .clk_sys (clk_sys),
    .reset   (reset),
    .raw     (ps2_dat_in),
    .sync    (dat_sync),
    .level   (dat_level),
    .fall    (dat_fall),
    .rise    (dat_rise)
  );

  logic unused_ok;
  assign unused_ok = ^{clk_sync, clk_rise, dat_fall, dat_rise};

  assign tx_ready = (state == IDLE) & ~reset;
  assign busy     = (state != IDLE);
  assign tx_done  = done_c & ~reset;
  assign tx_error = err_c & ~reset;
  assign timeout  = (tcnt == TMAX);

  always_comb begin
    state_n  = state;
    shift_n  = shift;
    idx_n    = idx;
    icnt_n   = icnt;
    tcnt_n   = tcnt;
    clk_oe_n = ps2_clk_oe;
    dat_oe_n = ps2_dat_oe;
    done_c   = 1'b0;
    err_c    = 1'b0;
    abort    = 1'b0;
    unique case (state)
      IDLE: begin
        if (tx_valid) begin
          shift_n  = {odd_parity(tx_data), tx_data};
          idx_n    = '0;
          icnt_n   = '0;
          tcnt_n   = '0;
          clk_oe_n = 1'b1;
          dat_oe_n = 1'b0;
          state_n  = INHIBIT;
        end
      end
      INHIBIT: begin
        // last inhibit cycle is the RTS cycle, so clock is low INHIBIT_CYCLES
        if (icnt == ILAST) begin
          dat_oe_n = 1'b1;
          state_n  = RTS;
        end else begin
          icnt_n = icnt + 1'b1;
        end
      end
      RTS: begin
        if (timeout) begin
          abort = 1'b1;
        end else begin
          clk_oe_n = 1'b0;
          tcnt_n   = '0;
          idx_n    = '0;
          state_n  = SEND;
        end
      end
      SEND: begin
        if (timeout) begin
          abort = 1'b1;
        end else begin
          tcnt_n = tcnt + 1'b1;
          if (clk_fall) begin
            if (idx == 4'd9) begin
              dat_oe_n = 1'b0;
              state_n  = ACK;
            end else begin
              dat_oe_n = ~shift[0];
              shift_n  = {1'b0, shift[8:1]};
              idx_n    = idx + 4'd1;
            end
          end
        end
      end
      ACK: begin
        if (timeout) begin
          abort = 1'b1;
        end else begin
          tcnt_n = tcnt + 1'b1;
          if (clk_fall) begin
            if (dat_level) abort = 1'b1;
            else state_n = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (timeout) begin
          abort = 1'b1;
        end else begin
          tcnt_n = tcnt + 1'b1;
          if (clk_level & dat_sync) begin
            done_c  = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (abort) begin
      err_c    = 1'b1;
      clk_oe_n = 1'b0;
      dat_oe_n = 1'b0;
      state_n  = IDLE;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= IDLE;
      shift      <= '0;
      idx        <= '0;
      icnt       <= '0;
      tcnt       <= '0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
    end else begin
      state      <= state_n;
      shift      <= shift_n;
      idx        <= idx_n;
      icnt       <= icnt_n;
      tcnt       <= tcnt_n;
      ps2_clk_oe <= clk_oe_n;
      ps2_dat_oe <= dat_oe_n;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device model.
// Scaled timing: short inhibit/timeout and a fast device clock.
module tb_ps2_host_tx;

  localparam int unsigned INH  = 96;
  localparam int unsigned TMO  = 3000;
  localparam int unsigned FL   = 8;
  localparam int unsigned HALF = 40;

  logic       clk_sys = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_error, busy;
  logic       ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;

  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO),
    .FILTER_LEN     (FL)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .busy       (busy),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  always #5 clk_sys = ~clk_sys;

  int unsigned cyc = 0, n_done = 0, n_err = 0, oe_hi = 0;
  int unsigned rel_cyc = 0, err_cyc = 0;
  logic [1:0]  pulse_oe = 2'b11;
  logic        ready_after = 1'b0;
  logic        chk_ready = 1'b0;
  logic        oe_q = 1'b0;

  always @(negedge clk_sys) begin
    cyc       <= cyc + 1;
    oe_q      <= ps2_clk_oe;
    chk_ready <= 1'b0;
    if (chk_ready) ready_after <= tx_ready;
    if (ps2_clk_oe) oe_hi <= oe_hi + 1;
    if (oe_q & ~ps2_clk_oe) rel_cyc <= cyc;
    if (tx_done) n_done <= n_done + 1;
    if (tx_error) begin
      n_err   <= n_err + 1;
      err_cyc <= cyc;
    end
    if (tx_done | tx_error) begin
      pulse_oe  <= {ps2_clk_oe, ps2_dat_oe};
      chk_ready <= 1'b1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       parity;
    logic       ack;
    logic       glitch;
    logic       exp_done;
    logic       exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic start_byte(input logic [7:0] d, input string tag,
                            output int unsigned o0);
    int w;
    check({tag, "_ready"}, tx_ready, 1'b1);
    o0 = oe_hi;
    tx_data  = d;
    tx_valid = 1'b1;
    tick(1);
    tx_data = ~d;
    tick(3);
    tx_valid = 1'b0;
    for (w = 0; w < int'(INH) + 50; w++) begin
      @(negedge clk_sys);
      if (!ps2_clk_oe) break;
    end
    check({tag, "_release_seen"}, w < int'(INH) + 50, 1'b1);
    tick(1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [10:0] fr;
    int unsigned d0, e0, o0;
    int w;
    d0 = n_done;
    e0 = n_err;
    start_byte(v.data, tag, o0);
    check({tag, "_inhibit_len"}, oe_hi - o0, INH);
    fr[0] = ps2_dat_in;
    tick(30);
    for (int k = 1; k <= 10; k++) begin
      dev_clk_low = 1'b1;
      tick(HALF);
      fr[k] = ps2_dat_in;
      dev_clk_low = 1'b0;
      if (v.glitch && k < 10) begin
        tick(HALF / 2);
        dev_clk_low = 1'b1;
        tick(3);
        dev_clk_low = 1'b0;
        tick(HALF / 2 - 3);
      end else if (k < 10) begin
        tick(HALF);
      end
    end
    tick(HALF / 2);
    if (v.ack) dev_dat_low = 1'b1;
    tick(HALF / 2);
    dev_clk_low = 1'b1;
    tick(HALF);
    dev_clk_low = 1'b0;
    tick(2);
    dev_dat_low = 1'b0;
    for (w = 0; w < int'(TMO); w++) begin
      if (n_done + n_err != d0 + e0) break;
      tick(1);
    end
    tick(3);
    check({tag, "_start"}, fr[0], 1'b0);
    check({tag, "_data"}, fr[8:1], v.data);
    check({tag, "_parity"}, fr[9], v.parity);
    check({tag, "_stop"}, fr[10], 1'b1);
    check({tag, "_done_cnt"}, n_done - d0, v.exp_done);
    check({tag, "_err_cnt"}, n_err - e0, v.exp_err);
    check({tag, "_oe_at_pulse"}, pulse_oe, 2'b00);
    check({tag, "_ready_after"}, ready_after, 1'b1);
    check({tag, "_busy_end"}, busy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned d0, e0, o0;
    int w;
    vecs[0] = '{8'hED, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'h07, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{8'h80, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    tick(3);
    @(negedge clk_sys);
    check("rst_ready", tx_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    check("rst_pulses", {tx_done, tx_error}, 2'b00);
    reset = 1'b0;
    tick(2);
    @(negedge clk_sys);
    check("post_rst_ready", tx_ready, 1'b1);
    tick(1);

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
      tick(10);
    end

    // Device never clocks: timeout measured from clock release.
    d0 = n_done;
    e0 = n_err;
    start_byte(8'h55, "tmo", o0);
    for (w = 0; w < int'(TMO) + 200; w++) begin
      if (n_err != e0) break;
      tick(1);
    end
    tick(3);
    check("tmo_err_cnt", n_err - e0, 1);
    check("tmo_done_cnt", n_done - d0, 0);
    check("tmo_latency", err_cyc - rel_cyc, TMO);
    check("tmo_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    check("tmo_ready_after", ready_after, 1'b1);
    tick(10);

    // Reset asserted during fall #5, then a full byte afterwards.
    d0 = n_done;
    e0 = n_err;
    start_byte(8'hC3, "rstx", o0);
    tick(30);
    for (int k = 1; k <= 4; k++) begin
      dev_clk_low = 1'b1;
      tick(HALF);
      dev_clk_low = 1'b0;
      tick(HALF);
    end
    dev_clk_low = 1'b1;
    tick(20);
    check("rstx_busy_before", busy, 1'b1);
    reset = 1'b1;
    tick(1);
    @(negedge clk_sys);
    check("rstx_oe", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
    check("rstx_ready_in_rst", tx_ready, 1'b0);
    tick(1);
    reset = 1'b0;
    dev_clk_low = 1'b0;
    tick(20);
    check("rstx_no_done", n_done - d0, 0);
    check("rstx_no_err", n_err - e0, 0);
    run_vec('{8'h5A, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
